// File: rtl/output_controller.sv
// UART transmit path: print bytes are queued in a circular FIFO and sent as 8N1 frames on txd.
// Latency: a byte written at edge N can be popped at edge N+1; txd drops for the start bit right after the pop.
// Backpressure: stall = print & full, combinational; the core holds print/WriteData until stall drops.
module output_controller #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int DEPTH            = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic       print,
  input  logic [7:0] WriteData,
  output logic       stall,
  output logic       idle,
  output logic       txd
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam logic [BW-1:0] BAUD_TOP = BW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          txd_q, txd_d;

  logic full, empty, push, pop, tick;

  // full is taken from the count at cycle start, so a same-cycle pop never un-stalls a print
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign stall = print & full;
  assign push  = print & ~full;
  assign pop   = (state_q == S_IDLE) & ~empty & tx_en;
  assign tick  = (baud_q == BAUD_TOP);
  assign txd   = txd_q;

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= WriteData;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // transmitter state register with its datapath and the registered line output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      txd_q   <= txd_d;
    end
  end

  // next-state: walk START, eight DATA bits and STOP, one bit period each
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = tick ? '0 : baud_q + BW'(1);
    case (state_q)
      S_IDLE: begin
        // baud counter parked at zero so START gets a full bit period
        baud_d = '0;
        if (pop) begin
          state_d = S_START;
          shift_d = mem_q[rptr_q];
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs: txd is registered from the next state so the line changes on the transition edge
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    idle = empty & (state_q == S_IDLE);
  end

endmodule

// File: tb/tb_output_controller.sv
// Bench for output_controller: table of single-frame waveforms, hand-written corner sequences,
// and randomized traffic checked by a queue-based byte model plus a UART line decoder.
module tb_output_controller;

  localparam int CPH   = 4;
  localparam int DEPTH = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       tx_en = 1'b0;
  logic       print = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       stall, idle, txd;

  output_controller #(.CLK_PER_HALF_BIT(CPH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .print(print), .WriteData(wdata),
    .stall(stall), .idle(idle), .txd(txd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model and line decoder ----------------
  logic [7:0] exp_q[$];       // bytes accepted but not yet seen on the line
  int         mcnt = 0;       // bytes held in the FIFO
  logic       pend_push = 1'b0;
  logic [7:0] pend_dat = 8'h00;
  logic       busy = 1'b0;
  int         off = 0;
  logic       prev_txd = 1'b1;
  logic [7:0] sh = 8'h00;
  int         n_starts = 0;
  int         cyc = 0;
  int         start_cyc[$];
  logic [7:0] dec_log[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      mcnt = 0; pend_push = 1'b0; busy = 1'b0; prev_txd = 1'b1; off = 0;
    end else begin
      if (pend_push) begin
        exp_q.push_back(pend_dat);
        mcnt++;
      end
      if (busy) begin
        off++;
        if (off == 4) chk("start_bit_mid", txd, 0);
        else if (off >= 12 && off <= 68 && (off - 4) % 8 == 0) sh[(off - 12) / 8] = txd;
        else if (off == 76) begin
          chk("stop_bit", txd, 1);
          busy = 1'b0;
          dec_log.push_back(sh);
          chk("frame_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("frame_byte", sh, exp_q.pop_front());
        end
      end else if (prev_txd && !txd) begin
        busy = 1'b1; off = 0; n_starts++;
        start_cyc.push_back(cyc);
        mcnt--;
      end
      prev_txd = txd;
      chk("stall", stall, (print && mcnt == DEPTH));
      pend_push = print && (mcnt != DEPTH);
      pend_dat  = wdata;
    end
  end

  // ---------------- helpers ----------------
  task automatic send(input logic [7:0] b);
    int n = 0;
    print = 1'b1;
    wdata = b;
    @(negedge clk);
    while (stall && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_dec(input int n, input int budget);
    int k = 0;
    while (dec_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_frames", (dec_log.size() >= n), 1);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (n_starts < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_start", (n_starts >= n), 1);
  endtask

  typedef struct {
    logic [7:0] dat;
    logic [9:0] seq;   // bit k = line level during the k-th bit period
  } vec_t;

  vec_t tbl[5];

  initial begin
    int lows, dbase, sbase, m;
    tbl[0] = '{dat: 8'hA5, seq: 10'b1101001010};
    tbl[1] = '{dat: 8'h00, seq: 10'b1000000000};
    tbl[2] = '{dat: 8'hFF, seq: 10'b1111111110};
    tbl[3] = '{dat: 8'h3C, seq: 10'b1001111000};
    tbl[4] = '{dat: 8'h81, seq: 10'b1100000010};

    // reset
    #2 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_idle", idle, 1);
    chk("reset_stall", stall, 0);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (!txd) lows++;
    end
    chk("quiet_line", lows, 0);

    // single-frame waveforms
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tx_en = 1'b1; print = 1'b1; wdata = tbl[i].dat;
      @(posedge clk); #1;
      print = 1'b0;
      @(negedge clk);
      chk("pre_start_txd", txd, 1);
      @(negedge clk);
      chk("start_edge_txd", txd, 0);
      repeat (4) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("vec%0d_bit%0d", i, k), txd, tbl[i].seq[k]);
        if (k == 5) chk("busy_not_idle", idle, 0);
        if (k < 9) repeat (8) @(negedge clk);
      end
      repeat (5) @(negedge clk);
      chk("post_frame_idle", idle, 1);
      chk("post_frame_txd", txd, 1);
    end

    // full / stall
    sbase = start_cyc.size();
    dbase = dec_log.size();
    @(posedge clk); #1;
    tx_en = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      print = 1'b1; wdata = 8'(b);
      @(posedge clk); #1;
    end
    wdata = 8'h05;
    @(negedge clk);
    chk("stall_when_full", stall, 1);
    repeat (3) begin
      @(negedge clk);
      chk("stall_held", stall, 1);
    end
    @(posedge clk); #1;
    tx_en = 1'b1;
    @(negedge clk);
    chk("stall_before_pop", stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stall_released", stall, 0);
    @(posedge clk); #1;
    print = 1'b0;
    wait_dec(dbase + 5, 1000);
    for (int j = 0; j < 5; j++) begin
      if (dec_log.size() > dbase + j) chk("full_order", dec_log[dbase + j], 8'(j + 1));
      if (j > 0 && start_cyc.size() > sbase + j)
        chk("start_spacing", start_cyc[sbase + j] - start_cyc[sbase + j - 1], 81);
    end

    // pointer wrap
    @(posedge clk); #1;
    dbase = dec_log.size();
    for (int j = 0; j < 10; j++) send(8'(8'h10 + j));
    print = 1'b0;
    wait_dec(dbase + 10, 2000);
    repeat (200) @(negedge clk);
    chk("wrap_count", dec_log.size(), dbase + 10);
    for (int j = 0; j < 10; j++)
      if (dec_log.size() > dbase + j) chk("wrap_order", dec_log[dbase + j], 8'(8'h10 + j));
    chk("wrap_idle", idle, 1);

    // tx_en dropped mid-frame
    @(posedge clk); #1;
    tx_en = 1'b0;
    send(8'h3C);
    send(8'h3D);
    print = 1'b0;
    sbase = n_starts;
    dbase = dec_log.size();
    tx_en = 1'b1;
    wait_starts(sbase + 1, 100);
    repeat (20) @(posedge clk);
    #1 tx_en = 1'b0;
    wait_dec(dbase + 1, 200);
    if (dec_log.size() > dbase) chk("txen_first", dec_log[dbase], 8'h3C);
    repeat (200) @(negedge clk);
    chk("txen_hold_starts", n_starts, sbase + 1);
    chk("txen_hold_txd", txd, 1);
    chk("txen_hold_not_idle", idle, 0);
    @(posedge clk); #1;
    tx_en = 1'b1;
    wait_dec(dbase + 2, 200);
    if (dec_log.size() > dbase + 1) chk("txen_second", dec_log[dbase + 1], 8'h3D);

    // reset mid-frame, bit 3 of 0xFF with two bytes queued
    @(posedge clk); #1;
    tx_en = 1'b0;
    send(8'hFF); send(8'hAA); send(8'hBB);
    print = 1'b0;
    sbase = n_starts;
    tx_en = 1'b1;
    wait_starts(sbase + 1, 100);
    repeat (36) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_txd", txd, 1);
    chk("arst_idle", idle, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", idle, 1);
    chk("post_rst_stall", stall, 0);
    sbase = n_starts;
    repeat (200) @(negedge clk);
    chk("post_rst_no_frames", n_starts, sbase);
    chk("post_rst_txd", txd, 1);

    // reset during a start bit: line must return high without a clock edge
    @(posedge clk); #1;
    send(8'h00);
    print = 1'b0;
    wait_starts(sbase + 1, 100);
    repeat (2) @(negedge clk);
    chk("start_low_before_rst", txd, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_start_txd", txd, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      @(negedge clk);
      m = mcnt;
      @(posedge clk); #1;
      tx_en = (m == DEPTH) ? 1'b1 : ($urandom_range(0, 3) != 0);
      send(8'($urandom));
      print = 1'b0;
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
    end
    tx_en = 1'b1;
    begin
      int k = 0;
      while ((exp_q.size() != 0 || !idle) && k < 5000) begin
        @(negedge clk);
        k++;
      end
    end
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_idle", idle, 1);
    chk("rand_txd", txd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/output_controller.md
# output_controller

Transmit-side counterpart of the core's UART input path. It accepts bytes from the core's print instruction into an internal FIFO and serialises them on `txd` as 8N1 UART frames. It asserts `stall` when the core issues a print while the FIFO is full. The UART bit period is set by the same half-bit parameter as the receive path, so both directions run at one baud rate.

## Interface
- `CLK_PER_HALF_BIT`, 5208, clock cycles per half UART bit. One bit period is 2·`CLK_PER_HALF_BIT` cycles. Must be ≥ 2.
- `DEPTH`, 256, FIFO depth in bytes. Power of two, ≥ 4.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_en`  in  1  start-of-frame enable. While low, no new frame begins; a frame already in flight completes.
- `print`  in  1  core write request, level, valid for one cycle per byte.
- `WriteData`  in  8  byte to transmit; sampled when `print & ~stall`.
- `stall`  out  1  `print & full`. Combinational.
- `idle`  out  1  FIFO empty and transmitter in IDLE. Registered-state derived.
- `txd`  out  1  UART serial output. Registered. Line idles high.

## Operation
- **FIFO**
  - Circular buffer with read/write pointers of log2(`DEPTH`) bits plus an occupancy count of log2(`DEPTH`)+1 bits.
  - `full` = count == `DEPTH`; `empty` = count == 0.
  - Pointers wrap modulo `DEPTH`.
- **Write**
  - When `print & ~full`, `WriteData` is stored at the write pointer and the pointer increments.
  - When `print & full`: `stall`=1 and nothing is written. The core holds `print`/`WriteData` until `stall` drops.
- **Simultaneous push and pop**
  - Count is unchanged; both pointers advance.
  - `full` is evaluated before the pop, so a print while full stalls for that cycle even if a pop occurs in the same cycle.
- **Transmitter FSM:** IDLE, START, DATA, STOP. Internal signals:
  - 8-bit shift register.
  - 3-bit bit index.
  - Baud counter counting 0..2·`CLK_PER_HALF_BIT`−1, with a `tick` when it reaches terminal count.
- **FSM transitions**
  - IDLE: `txd`=1. If `~empty & tx_en`, load the head byte into the shift register, pop the FIFO, clear the baud counter, and go to START.
  - START: `txd`=0 for one bit period; on `tick` go to DATA with bit index 0.
  - DATA: `txd` = shift[0] (LSB first). On `tick`, shift right; after bit index 7's `tick`, go to STOP, otherwise increment the bit index.
  - STOP: `txd`=1 for one bit period; on `tick` go to IDLE.
- **`tx_en` behaviour**
  - `tx_en` is examined only in IDLE.
  - Deasserting it mid-frame has no effect until the frame ends.
- **Reset (asynchronous, any time, including mid-frame)**
  - State = IDLE, `txd`=1, pointers and count = 0, baud counter = 0.
  - The partial frame is abandoned.
  - `stall`=0 (since `full`=0). `idle`=1.

## Timing
- Write latency: a byte written at edge N is visible as non-empty at edge N+1, so IDLE may pop it at edge N+1.
- `txd` falls (start bit) in the cycle after the IDLE→START edge.
- A frame occupies exactly 20·`CLK_PER_HALF_BIT` cycles from `txd` falling to the end of the stop bit.
- Back-to-back frames: each STOP→IDLE is followed by exactly one IDLE cycle before the next START. The start-to-start spacing is therefore 20·`CLK_PER_HALF_BIT`+1 cycles.
- `stall` is combinational from `print`, with no added latency.
- A print that stalls is accepted on the first edge where `full`=0 at cycle start.
- `idle` rises one cycle after the final STOP→IDLE transition when the FIFO is empty.

## Test plan
Bench uses `CLK_PER_HALF_BIT`=4 (bit = 8 cycles, frame = 80 cycles) and `DEPTH`=4.
- **Reset values:** hold `reset`=0 for 5 cycles, then release → `txd`=1, `idle`=1, `stall`=0, and `txd` stays high for 100 cycles with no prints.
- **Single byte:** print 0xA5 with `tx_en`=1 → `txd` sequence (8 cycles each) is 0, then 1,0,1,0,0,1,0,1, then 1. The start bit begins 2 cycles after the print edge. `idle` returns 1 after 80 cycles.
- **Full/stall:** with `tx_en`=0, print 0x01..0x05 on consecutive cycles → bytes 1–4 are accepted and the 5th sees `stall`=1. Raising `tx_en` pops 0x01 and the 5th is accepted the following cycle. The bench decodes 0x01,0x02,0x03,0x04,0x05 in order, with start-bit spacing of 81 cycles.
- **Pointer wrap:** push and drain 10 bytes 0x10..0x19 through the depth-4 FIFO → output is 0x10..0x19 in order, with no loss or duplication.
- **`tx_en` mid-frame:** drop `tx_en` during the DATA bits of byte 0x3C with 0x3D queued → 0x3C completes and `txd` then stays 1. Raising `tx_en` sends 0x3D.
- **Reset mid-frame:** assert `reset` during bit 3 of 0xFF with 2 bytes queued → `txd`=1 immediately (asynchronous). After release, `idle`=1 and no further frames are sent.
